// File: rtl/fft_frame_sequencer_if.sv
// Config and sample AXI-stream channels between the frame sequencer and the FFT core.
interface fft_frame_sequencer_if;
  logic [15:0] cfg_tdata_out;
  logic        cfg_tvalid_out;
  logic        cfg_tready_in;
  logic [31:0] data_tdata_out;
  logic        data_tvalid_out;
  logic        data_tlast_out;
  logic        data_tready_in;

  modport master (
    output cfg_tdata_out, cfg_tvalid_out,
    output data_tdata_out, data_tvalid_out, data_tlast_out,
    input  cfg_tready_in, data_tready_in
  );

  modport slave (
    input  cfg_tdata_out, cfg_tvalid_out,
    input  data_tdata_out, data_tvalid_out, data_tlast_out,
    output cfg_tready_in, data_tready_in
  );
endinterface

// File: rtl/fft_frame_sequencer.sv
// Configures the FFT core once per run, buffers mic samples and streams them as whole
// FRAME_LEN frames, zero-padding the open frame when the run is stopped.
module fft_frame_sequencer #(
  parameter int          FRAME_LEN  = 512,
  parameter int          SAMPLE_W   = 8,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [15:0] CFG_WORD   = 16'h0001
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  enable_in,
  input  logic [SAMPLE_W-1:0]   sample_in,
  input  logic                  sample_valid_in,
  fft_frame_sequencer_if.master fft,
  output logic                  frame_done_out,
  output logic                  overrun_out,
  output logic [15:0]           dropped_count_out,
  output logic                  busy_out
);
  localparam int CNT_W = $clog2(FRAME_LEN);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int MC_W  = PTR_W + 1;
  localparam int OCC_W = PTR_W + 2;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, CONFIG, STREAM, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [SAMPLE_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]    rdPtr_q, rdPtr_d;
  logic [MC_W-1:0]     memCount_q, memCount_d;
  logic [SAMPLE_W-1:0] outData_q, outData_d;
  logic                outValid_q, outValid_d;
  logic [CNT_W-1:0]    sampleCnt_q, sampleCnt_d;
  logic                frameDone_q, frameDone_d;
  logic                overrun_q, overrun_d;
  logic [15:0]         dropped_q, dropped_d;

  logic                pop;
  logic                lastBeat;
  logic                outFree;
  logic                memEmpty;
  logic                memRead;
  logic                memWrite;
  logic                pushReq;
  logic                pushAccept;
  logic                drop;
  logic                padBeat;
  logic                drainDone;
  logic                occFull;
  logic [OCC_W-1:0]    occupancy;
  logic [CNT_W-1:0]    nextIdx;
  logic [15:0]         realPart;

  // The output register counts as one of the FIFO_DEPTH buffered entries.
  assign pop        = outValid_q & fft.data_tready_in;
  assign lastBeat   = outValid_q & (sampleCnt_q == LAST_IDX);
  assign outFree    = ~outValid_q | pop;
  assign memEmpty   = (memCount_q == '0);
  assign occupancy  = OCC_W'(memCount_q) + OCC_W'(outValid_q);
  assign occFull    = (occupancy == FULL_OCC);
  assign nextIdx    = pop ? sampleCnt_q + CNT_W'(1) : sampleCnt_q;
  assign pushReq    = (state_q == STREAM) & sample_valid_in;
  assign pushAccept = pushReq & (~occFull | pop);
  assign drop       = pushReq & ~pushAccept;
  assign memWrite   = pushAccept & ~(outFree & memEmpty);
  assign padBeat    = (state_q == DRAIN) & (nextIdx != '0);
  assign drainDone  = memEmpty & outFree & (nextIdx == '0) & ~pushAccept;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= IDLE;
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      memCount_q  <= '0;
      outData_q   <= '0;
      outValid_q  <= 1'b0;
      sampleCnt_q <= '0;
      frameDone_q <= 1'b0;
      overrun_q   <= 1'b0;
      dropped_q   <= '0;
    end else begin
      state_q     <= state_d;
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      memCount_q  <= memCount_d;
      outData_q   <= outData_d;
      outValid_q  <= outValid_d;
      sampleCnt_q <= sampleCnt_d;
      frameDone_q <= frameDone_d;
      overrun_q   <= overrun_d;
      dropped_q   <= dropped_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (memWrite) begin
      mem_q[wrPtr_q] <= sample_in;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (enable_in) state_d = CONFIG;
      CONFIG: if (fft.cfg_tready_in) state_d = enable_in ? STREAM : IDLE;
      STREAM: if (!enable_in) state_d = drainDone ? IDLE : DRAIN;
      DRAIN:  if (drainDone) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Refill the output register from the FIFO first, then bypass a fresh sample,
  // then pad with zeros while a stopped frame is still open.
  always_comb begin
    outValid_d = outValid_q;
    outData_d  = outData_q;
    rdPtr_d    = rdPtr_q;
    memRead    = 1'b0;
    if (outFree) begin
      if (!memEmpty) begin
        outValid_d = 1'b1;
        outData_d  = mem_q[rdPtr_q];
        rdPtr_d    = rdPtr_q + PTR_W'(1);
        memRead    = 1'b1;
      end else if (pushAccept) begin
        outValid_d = 1'b1;
        outData_d  = sample_in;
      end else if (padBeat) begin
        outValid_d = 1'b1;
        outData_d  = '0;
      end else begin
        outValid_d = 1'b0;
      end
    end
  end

  always_comb begin
    wrPtr_d     = memWrite ? wrPtr_q + PTR_W'(1) : wrPtr_q;
    memCount_d  = memCount_q + MC_W'(memWrite) - MC_W'(memRead);
    sampleCnt_d = pop ? sampleCnt_q + CNT_W'(1) : sampleCnt_q;
    frameDone_d = pop & lastBeat;
    overrun_d   = overrun_q | drop;
    dropped_d   = dropped_q;
    if (drop && dropped_q != 16'hFFFF) begin
      dropped_d = dropped_q + 16'd1;
    end
  end

  assign realPart = 16'(outData_q) << (16 - SAMPLE_W);

  assign fft.cfg_tdata_out   = CFG_WORD;
  assign fft.cfg_tvalid_out  = (state_q == CONFIG);
  assign fft.data_tdata_out  = {16'h0000, realPart};
  assign fft.data_tvalid_out = outValid_q;
  assign fft.data_tlast_out  = lastBeat;
  assign frame_done_out      = frameDone_q;
  assign overrun_out         = overrun_q;
  assign dropped_count_out   = dropped_q;
  assign busy_out            = (state_q != IDLE);
endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed bench for the FFT frame sequencer: start-up vector table plus frame,
// overrun, stall, drain and reset sequences checked against a sample scoreboard.
module tb_fft_frame_sequencer;
  localparam int FRAME_LEN = 512;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        enable_in;
  logic [7:0]  sample_in;
  logic        sample_valid_in;
  logic        frame_done_out;
  logic        overrun_out;
  logic [15:0] dropped_count_out;
  logic        busy_out;

  fft_frame_sequencer_if fftIf();

  fft_frame_sequencer #(
    .FRAME_LEN(FRAME_LEN), .SAMPLE_W(8), .FIFO_DEPTH(16), .CFG_WORD(16'h0001)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .enable_in(enable_in),
    .sample_in(sample_in),
    .sample_valid_in(sample_valid_in),
    .fft(fftIf),
    .frame_done_out(frame_done_out),
    .overrun_out(overrun_out),
    .dropped_count_out(dropped_count_out),
    .busy_out(busy_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        en;
    logic        sv;
    logic [7:0]  smp;
    logic        cfgRdy;
    logic        dRdy;
    logic        expCfgValid;
    logic        expDValid;
    logic [31:0] expData;
    logic        expLast;
    logic        expBusy;
    logic        expDone;
  } vec_t;

  vec_t        vecs[12];
  int          checks = 0;
  int          failures = 0;
  logic [7:0]  expQ[$];
  int          tbBeat = 0;
  bit          monitorOn = 0;
  bit          stallPrev = 0;
  logic [33:0] stallSnap = '0;
  bit          doneExp = 0;
  int          frameDoneCount = 0;
  int          lastHsCount = 0;

  function automatic vec_t mkVec(logic en, logic sv, logic [7:0] smp, logic cfgRdy, logic dRdy,
                                 logic eCfg, logic eDv, logic [31:0] eData, logic eLast,
                                 logic eBusy, logic eDone);
    vec_t v;
    v.en = en; v.sv = sv; v.smp = smp; v.cfgRdy = cfgRdy; v.dRdy = dRdy;
    v.expCfgValid = eCfg; v.expDValid = eDv; v.expData = eData; v.expLast = eLast;
    v.expBusy = eBusy; v.expDone = eDone;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  // Scoreboard and AXI hold-rule monitor, evaluated mid-cycle while inputs are stable.
  task automatic monitorStep();
    logic [7:0]  e;
    logic [33:0] cur;
    if (!monitorOn) return;
    cur = {fftIf.data_tvalid_out, fftIf.data_tlast_out, fftIf.data_tdata_out};
    if (stallPrev) checkOutput("stallHold", 64'(cur), 64'(stallSnap));
    checkOutput("frameDone", 64'(frame_done_out), 64'(doneExp));
    if (frame_done_out) frameDoneCount++;
    doneExp = 0;
    if (fftIf.data_tvalid_out && fftIf.data_tready_in) begin
      checkOutput("beatExpected", 64'(expQ.size() > 0), 64'(1));
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput($sformatf("beatData[%0d]", tbBeat), 64'(fftIf.data_tdata_out),
                    64'({16'h0000, e, 8'h00}));
        checkOutput($sformatf("beatLast[%0d]", tbBeat), 64'(fftIf.data_tlast_out),
                    64'(tbBeat == FRAME_LEN - 1));
        if (tbBeat == FRAME_LEN - 1) begin
          doneExp = 1;
          lastHsCount++;
        end
        tbBeat = (tbBeat + 1) % FRAME_LEN;
      end
    end
    stallPrev = fftIf.data_tvalid_out && !fftIf.data_tready_in;
    stallSnap = cur;
  endtask

  task automatic tick();
    @(negedge clk_in);
    monitorStep();
    @(posedge clk_in);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    enable_in            = v.en;
    sample_valid_in      = v.sv;
    sample_in            = v.smp;
    fftIf.cfg_tready_in  = v.cfgRdy;
    fftIf.data_tready_in = v.dRdy;
    tick();
  endtask

  task automatic sendSample(input logic [7:0] v);
    sample_in       = v;
    sample_valid_in = 1'b1;
    expQ.push_back(v);
    tick();
  endtask

  task automatic waitEmpty(input int bound);
    for (int c = 0; c < bound && expQ.size() != 0; c++) tick();
    checkOutput("drainTimeout", 64'(expQ.size()), 64'(0));
    tick();
  endtask

  initial begin
    int sent;
    int lastStart;

    rst_in = 1'b0; enable_in = 1'b0; sample_in = '0; sample_valid_in = 1'b0;
    fftIf.cfg_tready_in = 1'b0; fftIf.data_tready_in = 1'b0;
    #3;
    checkOutput("rstCfgData", 64'(fftIf.cfg_tdata_out), 64'(16'h0001));
    checkOutput("rstCfgValid", 64'(fftIf.cfg_tvalid_out), 64'(0));
    checkOutput("rstDValid", 64'(fftIf.data_tvalid_out), 64'(0));
    checkOutput("rstDData", 64'(fftIf.data_tdata_out), 64'(0));
    checkOutput("rstLast", 64'(fftIf.data_tlast_out), 64'(0));
    checkOutput("rstMisc", 64'({frame_done_out, overrun_out, dropped_count_out, busy_out}), 64'(0));
    tick();
    tick();
    rst_in = 1'b1;
    monitorOn = 1;

    vecs[0]  = mkVec(1, 0, 8'h00, 0, 1, 1, 0, 32'h0, 0, 1, 0);
    vecs[1]  = mkVec(1, 0, 8'h00, 0, 1, 1, 0, 32'h0, 0, 1, 0);
    vecs[2]  = mkVec(1, 0, 8'h00, 0, 1, 1, 0, 32'h0, 0, 1, 0);
    vecs[3]  = mkVec(1, 0, 8'h00, 0, 1, 1, 0, 32'h0, 0, 1, 0);
    vecs[4]  = mkVec(1, 0, 8'h00, 1, 1, 0, 0, 32'h0, 0, 1, 0);
    vecs[5]  = mkVec(1, 1, 8'h11, 0, 0, 0, 1, 32'h00001100, 0, 1, 0);
    vecs[6]  = mkVec(1, 1, 8'h22, 0, 0, 0, 1, 32'h00001100, 0, 1, 0);
    vecs[7]  = mkVec(1, 0, 8'h00, 0, 1, 0, 1, 32'h00002200, 0, 1, 0);
    vecs[8]  = mkVec(1, 0, 8'h00, 0, 1, 0, 0, 32'h0, 0, 1, 0);
    vecs[9]  = mkVec(1, 1, 8'h33, 0, 1, 0, 1, 32'h00003300, 0, 1, 0);
    vecs[10] = mkVec(1, 1, 8'h44, 0, 1, 0, 1, 32'h00004400, 0, 1, 0);
    vecs[11] = mkVec(1, 0, 8'h00, 0, 1, 0, 0, 32'h0, 0, 1, 0);
    expQ.push_back(8'h11); expQ.push_back(8'h22); expQ.push_back(8'h33); expQ.push_back(8'h44);

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d.cfgValid", i), 64'(fftIf.cfg_tvalid_out), 64'(vecs[i].expCfgValid));
      checkOutput($sformatf("vec%0d.dValid", i), 64'(fftIf.data_tvalid_out), 64'(vecs[i].expDValid));
      checkOutput($sformatf("vec%0d.last", i), 64'(fftIf.data_tlast_out), 64'(vecs[i].expLast));
      checkOutput($sformatf("vec%0d.busy", i), 64'(busy_out), 64'(vecs[i].expBusy));
      checkOutput($sformatf("vec%0d.done", i), 64'(frame_done_out), 64'(vecs[i].expDone));
      if (vecs[i].expDValid)
        checkOutput($sformatf("vec%0d.data", i), 64'(fftIf.data_tdata_out), 64'(vecs[i].expData));
    end

    // Finish the first frame at full rate.
    fftIf.data_tready_in = 1'b1;
    for (int i = 4; i < FRAME_LEN; i++) sendSample(8'(i));
    sample_valid_in = 1'b0;
    waitEmpty(50);
    checkOutput("frame1DoneCount", 64'(frameDoneCount), 64'(1));

    // Second frame with random sink stalls, source throttled to avoid overruns.
    sent = 0;
    for (int c = 0; c < 4000 && sent < FRAME_LEN; c++) begin
      fftIf.data_tready_in = ($urandom_range(0, 3) != 0);
      if (expQ.size() < 14 && $urandom_range(0, 1) == 1) begin
        sample_in       = 8'(sent);
        sample_valid_in = 1'b1;
        expQ.push_back(8'(sent));
        sent++;
      end else begin
        sample_valid_in = 1'b0;
      end
      tick();
    end
    sample_valid_in = 1'b0;
    fftIf.data_tready_in = 1'b1;
    waitEmpty(100);
    checkOutput("frame2DoneCount", 64'(frameDoneCount), 64'(2));
    checkOutput("noOverrunYet", 64'(overrun_out), 64'(0));

    // Overrun: sink blocked while 20 samples arrive back to back.
    fftIf.data_tready_in = 1'b0;
    for (int i = 0; i < 20; i++) begin
      sample_in       = 8'hA0 + 8'(i);
      sample_valid_in = 1'b1;
      if (i < 16) expQ.push_back(8'hA0 + 8'(i));
      tick();
    end
    sample_valid_in = 1'b0;
    checkOutput("overrunSticky", 64'(overrun_out), 64'(1));
    checkOutput("droppedCount", 64'(dropped_count_out), 64'(4));
    checkOutput("stalledHead", 64'(fftIf.data_tdata_out), 64'(32'h0000A000));
    fftIf.data_tready_in = 1'b1;
    for (int k = 0; k < 16; k++) begin
      checkOutput($sformatf("noGap%0d", k), 64'(fftIf.data_tvalid_out), 64'(1));
      tick();
    end
    checkOutput("fifoEmptied", 64'(fftIf.data_tvalid_out), 64'(0));
    checkOutput("overrunBeats", 64'(expQ.size()), 64'(0));

    // Stop after 100 beats of the third frame: remainder must be zero padded.
    for (int i = 16; i < 100; i++) sendSample(8'(i));
    sample_valid_in = 1'b0;
    enable_in       = 1'b0;
    for (int i = 100; i < FRAME_LEN; i++) expQ.push_back(8'h00);
    lastStart = lastHsCount;
    for (int c = 0; c < 1000 && lastHsCount == lastStart; c++) tick();
    checkOutput("drainTlastSeen", 64'(lastHsCount), 64'(lastStart + 1));
    checkOutput("drainBusyLow", 64'(busy_out), 64'(0));
    checkOutput("drainValidLow", 64'(fftIf.data_tvalid_out), 64'(0));
    checkOutput("drainAllBeats", 64'(expQ.size()), 64'(0));

    for (int k = 0; k < 5; k++) begin
      sample_in       = 8'h77;
      sample_valid_in = 1'b1;
      tick();
      checkOutput($sformatf("idleNoValid%0d", k), 64'(fftIf.data_tvalid_out), 64'(0));
      checkOutput($sformatf("idleBusy%0d", k), 64'(busy_out), 64'(0));
    end
    sample_valid_in = 1'b0;
    checkOutput("idleNoDrop", 64'(dropped_count_out), 64'(4));
    checkOutput("frame3DoneCount", 64'(frameDoneCount), 64'(3));

    // Restart, leave a stalled beat in flight, then reset mid-frame.
    enable_in = 1'b1;
    fftIf.cfg_tready_in = 1'b1;
    tick();
    checkOutput("restartConfig", 64'(fftIf.cfg_tvalid_out), 64'(1));
    tick();
    fftIf.cfg_tready_in  = 1'b0;
    fftIf.data_tready_in = 1'b0;
    checkOutput("restartStream", 64'({busy_out, fftIf.cfg_tvalid_out}), 64'(2'b10));
    sendSample(8'h5A);
    sample_valid_in = 1'b0;
    checkOutput("preResetValid", 64'(fftIf.data_tvalid_out), 64'(1));
    monitorOn = 0;
    rst_in = 1'b0;
    #1;
    checkOutput("midRstDValid", 64'(fftIf.data_tvalid_out), 64'(0));
    checkOutput("midRstData", 64'(fftIf.data_tdata_out), 64'(0));
    checkOutput("midRstLast", 64'(fftIf.data_tlast_out), 64'(0));
    checkOutput("midRstCfgValid", 64'(fftIf.cfg_tvalid_out), 64'(0));
    checkOutput("midRstOverrun", 64'(overrun_out), 64'(0));
    checkOutput("midRstDropped", 64'(dropped_count_out), 64'(0));
    checkOutput("midRstBusy", 64'(busy_out), 64'(0));
    checkOutput("midRstCfgData", 64'(fftIf.cfg_tdata_out), 64'(16'h0001));
    expQ.delete();
    tbBeat = 0; stallPrev = 0; doneExp = 0;
    tick();
    rst_in = 1'b1;
    monitorOn = 1;
    tick();
    checkOutput("postRstConfig", 64'(fftIf.cfg_tvalid_out), 64'(1));
    enable_in = 1'b0;
    tick();
    checkOutput("configNoAbort", 64'(fftIf.cfg_tvalid_out), 64'(1));
    fftIf.cfg_tready_in = 1'b1;
    tick();
    checkOutput("configToIdle", 64'({busy_out, fftIf.cfg_tvalid_out}), 64'(0));
    fftIf.cfg_tready_in = 1'b0;
    tick();
    checkOutput("idleAfterCfg", 64'({busy_out, fftIf.data_tvalid_out}), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fft_frame_sequencer.md
Name: fft_frame_sequencer

Overview:
Sequences the audio path into the 512-point FFT core. Performs the one-time FFT config handshake, buffers 8-bit mic samples in a small FIFO, and streams them on the FFT AXI-stream slave port with a correct tlast every FRAME_LEN samples. Handles backpressure, overruns and clean shutdown (zero-pads the open frame), so the FFT and biometrics stages downstream always see whole frames.

Parameters:
FRAME_LEN, 512, samples per FFT frame (power of two, >=4)
SAMPLE_W, 8, width of incoming audio sample
FIFO_DEPTH, 16, sample buffer entries (power of two)
CFG_WORD, 16'h0001, value sent on config channel (bit0=1 forward FFT)

Ports:
clk_in  input  1  system clock (98.304 MHz audio clock domain)
rst_in  input  1  reset, asynchronous, active-low
enable_in  input  1  level; 1 = run, 0 = finish current frame and stop
sample_in  input  SAMPLE_W  signed audio sample
sample_valid_in  input  1  one-cycle strobe, sample_in valid
cfg_tdata_out  output  16  FFT config data
cfg_tvalid_out  output  1  FFT config valid
cfg_tready_in  input  1  FFT config ready
data_tdata_out  output  32  FFT input {16'h0000 imag, sample, 8'h00 real}
data_tvalid_out  output  1  FFT input valid
data_tlast_out  output  1  last sample of frame
data_tready_in  input  1  FFT input ready
frame_done_out  output  1  one-cycle pulse on the tlast handshake
overrun_out  output  1  sticky: a sample was dropped since reset
dropped_count_out  output  16  dropped samples, saturates at 16'hFFFF
busy_out  output  1  1 in any state except IDLE

Behaviour:
- Reset (rst_in=0, async): state=IDLE, FIFO empty, sample counter 0. All outputs 0, except cfg_tdata_out=CFG_WORD (constant).
- States: IDLE, CONFIG, STREAM, DRAIN.
- IDLE: samples ignored. enable_in=1 -> CONFIG.
- CONFIG: cfg_tvalid_out=1 until the cycle cfg_tvalid_out&cfg_tready_in; then -> STREAM. Config is sent on every IDLE->CONFIG entry. enable_in dropping in CONFIG does not abort; after the handshake -> DRAIN (frame empty, so it ends immediately in IDLE).
- STREAM: sample_valid_in pushes sample_in into the FIFO. enable_in=0 -> DRAIN.
- DRAIN: no pushes. The FIFO is emptied onto the data port, then zeros are sent until the sample counter wraps (tlast). Then -> IDLE. If the counter is 0 and the FIFO is empty on entry, go straight to IDLE with no transfer.
- Output stage is a registered FIFO head.
  - A push into an empty FIFO with the output idle gives data_tvalid_out=1 on the next cycle (latency 1).
  - Once asserted, data_tvalid_out, data_tdata_out and data_tlast_out hold until data_tready_in=1 (AXI rule).
  - Back-to-back transfers sustain 1 sample/cycle.
- Sample counter: log2(FRAME_LEN) bits. Increments on each data handshake and wraps FRAME_LEN-1 -> 0. data_tlast_out = (counter==FRAME_LEN-1) on the presented beat. frame_done_out pulses in the cycle after the tlast handshake.
- Full FIFO:
  - Push with simultaneous pop: both occur, count unchanged.
  - Push without pop: sample dropped, overrun_out set, dropped_count_out increments (saturating).
  - Drops do not alter the frame counter, so frames stay FRAME_LEN long.
- Empty FIFO in STREAM: data_tvalid_out=0; no padding.
- sample_valid_in in IDLE, CONFIG or DRAIN: ignored, not counted as a drop.
- Reset mid-frame: everything clears immediately. The FFT core must be reset alongside this block.
- overrun_out and dropped_count_out clear only on reset.

Test Plan:
- Reset, enable_in=1, cfg_tready_in=1 after 3 cycles -> cfg_tvalid_out high exactly 4 cycles; then STREAM, busy_out=1.
- 512 samples (value = index mod 256), data_tready_in=1 -> 512 beats; tdata[15:8] matches input; tlast only on beat 511; frame_done_out one pulse; second frame counter restarts at 0.
- data_tready_in=0 for 20 cycles while 20 samples arrive on consecutive cycles -> first 16 buffered, 4 dropped; overrun_out=1; dropped_count_out=4; after release the 16 buffered samples are output in order with no gaps.
- Random data_tready_in stalls -> tvalid/tdata/tlast never change while stalled; no beats lost or duplicated.
- enable_in=0 after 100 samples transferred -> remaining FIFO data, then 412 zero beats, tlast on the final one, busy_out=0 next cycle; later samples ignored.
- rst_in low for 1 cycle mid-frame with tvalid high -> all outputs 0 at once; dropped_count_out=0; new enable restarts with the config handshake.
